// File: rtl/seg_mode_ctrl.sv
// seg_mode_ctrl: debounced mode-button controller and 7-segment source selector.
// Cycles mode_sel through NUM_MODES sources on each accepted press, blanks the
// display for BLANK_CYCLES after a mode change, and registers the selected
// seg_data/seg_com channel.
// Optional feature macro: SEG_MODE_LONGPRESS_EN (long hold forces mode 0).
module seg_mode_ctrl #(
    parameter int unsigned NUM_MODES    = 3,
    parameter int unsigned SEG_W        = 8,
    parameter int unsigned DEBOUNCE_CNT = 20,
    parameter int unsigned BLANK_CYCLES = 5,
    parameter int unsigned LONG_CNT     = 1000,
    localparam int unsigned MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode_btn,
    input  logic                       mode_lock,
    input  logic [NUM_MODES*SEG_W-1:0] seg_data_in,
    input  logic [NUM_MODES*SEG_W-1:0] seg_com_in,
    output logic [SEG_W-1:0]           seg_data,
    output logic [SEG_W-1:0]           seg_com,
    output logic [MODE_W-1:0]          mode_sel,
    output logic [NUM_MODES-1:0]       mode_onehot,
    output logic                       mode_changed
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    logic                 sync1_q, sync2_q;
    logic                 db_level_q, db_level_d;
    logic                 db_prev_q;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [NUM_MODES-1:0] onehot_q, onehot_d;
    logic                 changed_q, changed_d;
    logic [SEG_W-1:0]     seg_data_q, seg_data_d;
    logic [SEG_W-1:0]     seg_com_q, seg_com_d;
    logic [SEG_W-1:0]     data_sel_c, com_sel_c;
    logic                 press_c;

`ifdef SEG_MODE_LONGPRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_CNT + 1);
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_fire_c;
`else
    logic unused_long_c;
    assign unused_long_c = (LONG_CNT != 0);
`endif

    // State registers: synchroniser, debouncer, mode, blanking and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_level_q  <= 1'b0;
            db_prev_q   <= 1'b0;
            db_cnt_q    <= '0;
            blank_q     <= '0;
            mode_q      <= '0;
            onehot_q    <= NUM_MODES'(1);
            changed_q   <= 1'b0;
            seg_data_q  <= '0;
            seg_com_q   <= '1;
`ifdef SEG_MODE_LONGPRESS_EN
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= mode_btn;
            sync2_q     <= sync1_q;
            db_level_q  <= db_level_d;
            db_prev_q   <= db_level_q;
            db_cnt_q    <= db_cnt_d;
            blank_q     <= blank_d;
            mode_q      <= mode_d;
            onehot_q    <= onehot_d;
            changed_q   <= changed_d;
            seg_data_q  <= seg_data_d;
            seg_com_q   <= seg_com_d;
`ifdef SEG_MODE_LONGPRESS_EN
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
`endif
        end
    end

    // Next-state: debounce, press detect, mode advance, blanking and output mux
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        mode_d     = mode_q;
        changed_d  = 1'b0;
        blank_d    = (blank_q != '0) ? blank_q - BLANK_W'(1) : '0;
        onehot_d   = '0;
        data_sel_c = seg_data_in[SEG_W-1:0];
        com_sel_c  = seg_com_in[SEG_W-1:0];

        // Level flips only after DEBOUNCE_CNT consecutive differing samples
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Rising edge of the debounced level is a press; locked presses are dropped
        press_c = db_level_q & ~db_prev_q;
        if (press_c && !mode_lock) begin
            mode_d    = (32'(mode_q) >= NUM_MODES - 1) ? '0 : mode_q + MODE_W'(1);
            changed_d = 1'b1;
            blank_d   = BLANK_W'(BLANK_CYCLES);
        end

`ifdef SEG_MODE_LONGPRESS_EN
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        long_fire_c = 1'b0;
        if (!db_level_q) begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (!long_done_q) begin
            if (long_cnt_q == LONG_W'(LONG_CNT - 1)) begin
                long_done_d = 1'b1;
                long_cnt_d  = '0;
                long_fire_c = !mode_lock;
            end else begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
            end
        end
        if (long_fire_c) begin
            mode_d    = '0;
            changed_d = 1'b1;
            blank_d   = BLANK_W'(BLANK_CYCLES);
        end
`endif

        for (int unsigned k = 0; k < NUM_MODES; k++) begin
            onehot_d[k] = (32'(mode_d) == k);
        end

        // Out-of-range mode indices fall back to channel 0
        for (int unsigned k = 1; k < NUM_MODES; k++) begin
            if (32'(mode_q) == k) begin
                data_sel_c = seg_data_in[k*SEG_W +: SEG_W];
                com_sel_c  = seg_com_in[k*SEG_W +: SEG_W];
            end
        end

        seg_data_d = (blank_q != '0) ? '0 : data_sel_c;
        seg_com_d  = (blank_q != '0) ? '1 : com_sel_c;
    end

    assign seg_data     = seg_data_q;
    assign seg_com      = seg_com_q;
    assign mode_sel     = mode_q;
    assign mode_onehot  = onehot_q;
    assign mode_changed = changed_q;

endmodule

// File: tb/tb_seg_mode_ctrl.sv
// Directed testbench for seg_mode_ctrl: per-cycle vector table for a clean
// press/release, then hand-written wrap, bounce, lock and async-reset sequences.
module tb_seg_mode_ctrl;

    localparam int unsigned NUM_MODES = 3;
    localparam int unsigned SEG_W     = 8;

    logic                       clk;
    logic                       rst;
    logic                       mode_btn;
    logic                       mode_lock;
    logic [NUM_MODES*SEG_W-1:0] seg_data_in;
    logic [NUM_MODES*SEG_W-1:0] seg_com_in;
    logic [SEG_W-1:0]           seg_data;
    logic [SEG_W-1:0]           seg_com;
    logic [1:0]                 mode_sel;
    logic [NUM_MODES-1:0]       mode_onehot;
    logic                       mode_changed;

    int vec_cnt;
    int err_cnt;

    typedef struct {
        logic       btn;
        logic [1:0] mode;
        logic       chg;
        logic [7:0] data;
        logic [7:0] com;
    } vec_t;

    vec_t tbl[18];

    seg_mode_ctrl #(
        .NUM_MODES   (NUM_MODES),
        .SEG_W       (SEG_W),
        .DEBOUNCE_CNT(4),
        .BLANK_CYCLES(2),
        .LONG_CNT    (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_btn    (mode_btn),
        .mode_lock   (mode_lock),
        .seg_data_in (seg_data_in),
        .seg_com_in  (seg_com_in),
        .seg_data    (seg_data),
        .seg_com     (seg_com),
        .mode_sel    (mode_sel),
        .mode_onehot (mode_onehot),
        .mode_changed(mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the button for 'hi' cycles then release for 'lo' cycles, counting pulses
    task automatic press(input int hi, input int lo, output int pulses);
        pulses   = 0;
        mode_btn = 1'b1;
        for (int i = 0; i < hi; i++) begin
            step();
            if (mode_changed) pulses++;
        end
        mode_btn = 1'b0;
        for (int i = 0; i < lo; i++) begin
            step();
            if (mode_changed) pulses++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mode"},   int'(mode_sel),     0);
        chk({tag, "_onehot"}, int'(mode_onehot),  1);
        chk({tag, "_com"},    int'(seg_com),      'hFF);
        chk({tag, "_data"},   int'(seg_data),     0);
        chk({tag, "_chg"},    int'(mode_changed), 0);
    endtask

    initial begin
        int     pulses;
        bit     found;
        logic [2:0] exp_oh[3];

        vec_cnt = 0;
        err_cnt = 0;

        // Source channels: data A5/3C/C3, commons FE/FD/FB
        seg_data_in = {8'hC3, 8'h3C, 8'hA5};
        seg_com_in  = {8'hFB, 8'hFD, 8'hFE};
        mode_btn    = 1'b0;
        mode_lock   = 1'b0;
        rst         = 1'b0;

        // Clean press from mode 0: rise -> 2 sync + 4 debounce + 1 edge detect
        for (int i = 0; i < 18; i++) begin
            tbl[i].btn  = (i < 10);
            tbl[i].mode = (i < 6) ? 2'd0 : 2'd1;
            tbl[i].chg  = (i == 6);
            tbl[i].data = 8'h3C;
            tbl[i].com  = 8'hFD;
            if (i <= 6) begin
                tbl[i].data = 8'hA5;
                tbl[i].com  = 8'hFE;
            end else if (i <= 8) begin
                tbl[i].data = 8'h00;
                tbl[i].com  = 8'hFF;
            end
        end

        // Reset state while rst is held low
        #12;
        chk_reset_outputs("rst_hold");

        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst_rel_data", int'(seg_data), 'hA5);
        chk("rst_rel_com",  int'(seg_com),  'hFE);

        // Table-driven clean press and release
        for (int i = 0; i < 18; i++) begin
            mode_btn = tbl[i].btn;
            step();
            chk($sformatf("tbl%0d_mode", i), int'(mode_sel),     int'(tbl[i].mode));
            chk($sformatf("tbl%0d_chg", i),  int'(mode_changed), int'(tbl[i].chg));
            chk($sformatf("tbl%0d_data", i), int'(seg_data),     int'(tbl[i].data));
            chk($sformatf("tbl%0d_com", i),  int'(seg_com),      int'(tbl[i].com));
        end
        chk("tbl_onehot", int'(mode_onehot), 'b010);

        // Wrap: three presses from reset give 1, 2, 0
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        exp_oh[0] = 3'b010;
        exp_oh[1] = 3'b100;
        exp_oh[2] = 3'b001;
        for (int p = 0; p < 3; p++) begin
            press(10, 10, pulses);
            chk($sformatf("wrap%0d_pulses", p), pulses, 1);
            chk($sformatf("wrap%0d_mode", p),   int'(mode_sel), (p + 1) % 3);
            chk($sformatf("wrap%0d_onehot", p), int'(mode_onehot), int'(exp_oh[p]));
        end

        // Bounce: toggle every 2 cycles for 20 cycles, never stable for 4
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            mode_btn = ((i / 2) % 2 == 0);
            step();
            if (mode_changed) pulses++;
        end
        mode_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mode_changed) pulses++;
        end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_mode",   int'(mode_sel), 0);

        // Lock: press while locked, unlock while still held, then release
        mode_lock = 1'b1;
        pulses    = 0;
        mode_btn  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mode_changed) pulses++;
        end
        mode_lock = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mode_changed) pulses++;
        end
        mode_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mode_changed) pulses++;
        end
        chk("lock_pulses", pulses, 0);
        chk("lock_mode",   int'(mode_sel), 0);
        press(10, 10, pulses);
        chk("unlock_pulses", pulses, 1);
        chk("unlock_mode",   int'(mode_sel), 1);

        // Async reset one cycle after a mode change, mid-blank
        found    = 1'b0;
        mode_btn = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (mode_changed) found = 1'b1;
        end
        chk("blank_pulse_seen", int'(found), 1);
        step();
        chk("blank_mid_com", int'(seg_com),  'hFF);
        chk("blank_mid_mode", int'(mode_sel), 2);
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        mode_btn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_data", int'(seg_data), 'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seg_mode_ctrl.md
Name: seg_mode_ctrl

Overview:
Parametrised mode controller and 7-segment display selector for the top-level application. Cycles through NUM_MODES display sources (watch, stopwatch, alarm, ...) on a debounced, edge-detected mode button, all synchronous to one clock. Drives registered seg_data/seg_com from the active source, blanks the display briefly on each mode change, and exposes the current mode for LEDs and sub-blocks.

Parameters:
NUM_MODES, 3, number of selectable display sources (2..8)
SEG_W, 8, width of each seg_data and each seg_com channel
DEBOUNCE_CNT, 20, consecutive stable cycles needed to accept a button level change (20 ms at 1 kHz)
BLANK_CYCLES, 5, display-off cycles after each mode change (0 = no blanking)
LONG_CNT, 1000, hold cycles for a long press (used only with the optional feature)

Ports:
clk  in  1  system clock (1 kHz); single clock domain
rst  in  1  asynchronous, active-low reset
mode_btn  in  1  raw mode push-button, asynchronous to clk, active-high
mode_lock  in  1  high = mode changes inhibited (e.g. while a setting mode is active)
seg_data_in  in  NUM_MODES*SEG_W  packed source data; mode k at bits [k*SEG_W +: SEG_W]
seg_com_in  in  NUM_MODES*SEG_W  packed source commons, same packing
seg_data  out  SEG_W  registered selected segment data
seg_com  out  SEG_W  registered selected digit commons (active-low digit enable)
mode_sel  out  MODE_W  current mode index; MODE_W = max(1, clog2(NUM_MODES))
mode_onehot  out  NUM_MODES  one-hot copy of mode_sel, for LEDs
mode_changed  out  1  one-cycle pulse when mode_sel updates

Behaviour:
- Reset (rst low, asynchronous): mode_sel=0, mode_onehot=1, seg_data=0, seg_com=all 1 (all digits off), mode_changed=0, synchroniser and debounced level=0, debounce, blank and long-press counters=0.
- mode_btn passes through a 2-FF synchroniser. The debounced level changes only after the synchronised value differs from it for DEBOUNCE_CNT consecutive cycles. Any bounce restarts the count.
- Accepted press = 0->1 edge of the debounced level. A release never advances the mode.
- On an accepted press with mode_lock=0: on the next clk edge, mode_sel advances by 1 and wraps from NUM_MODES-1 to 0. mode_onehot updates in the same cycle, mode_changed=1 for exactly that cycle, and the blank counter loads BLANK_CYCLES.
- With mode_lock=1 the press is discarded, not queued: no advance, no pulse. Deasserting the lock while the button is still held does not advance the mode.
- A press accepted while blanking is active advances normally and reloads the blank counter.
- Output path: while the blank counter is nonzero, seg_data=0 and seg_com=all 1, and the counter decrements each cycle. Otherwise seg_data/seg_com register the channel selected by mode_sel, giving 1-cycle latency from seg_*_in.
- mode_sel values >= NUM_MODES never occur. Defensively, they select channel 0.
- Reset mid-blank or mid-debounce aborts immediately to the reset state.

Optional Feature:
SEG_MODE_LONGPRESS_EN
- Defined: while the debounced level stays high, a counter runs. When it reaches LONG_CNT with mode_lock=0, mode_sel is forced to 0 with a mode_changed pulse and blanking. This happens once per hold; a new hold is needed before it can trigger again.
- Not defined: the counter and logic are absent, LONG_CNT is ignored, and holding the button has no effect beyond the initial press.

Test Plan:
- Reset: with rst=0, outputs are mode_sel=0, mode_onehot=3'b001, seg_com=8'hFF, seg_data=8'h00. Release rst with source 0 at data=8'hA5, com=8'hFE: after 1 cycle, seg_data=8'hA5, seg_com=8'hFE.
- Clean press (DEBOUNCE_CNT=4, BLANK_CYCLES=2): hold mode_btn high for 10 cycles. mode_sel goes 0->1 exactly 2+4+1 cycles after the rise, with a single mode_changed pulse. Then seg_com=8'hFF for 2 cycles, then source 1 values appear.
- Wrap: three accepted presses from reset give the mode_sel sequence 1,2,0 and mode_onehot 010,100,001.
- Bounce: toggle mode_btn every 2 cycles for 20 cycles, then hold low. There is no mode change and no mode_changed pulse.
- Lock: with mode_lock=1, make a clean press, then drop mode_lock while the button is still held. mode_sel stays 0 throughout; the next clean press moves it to 1.
- Async reset mid-blank: assert rst one cycle after mode_changed. All outputs return to reset values immediately, without waiting for clk.
